// File: rtl/dpram_port_arbiter_pkg.sv
// Shared constants for the dual-port RAM arbiter slice.
package dpram_pkg;
    localparam int AW     = 6;
    localparam int DW     = 64;
    localparam int DEPTH  = 64;
    localparam int COLL_W = 16;

    localparam logic [COLL_W-1:0] COLL_MAX = {COLL_W{1'b1}};

    function automatic logic [COLL_W-1:0] sat_inc(input logic [COLL_W-1:0] v);
        return (v == COLL_MAX) ? v : v + COLL_W'(1);
    endfunction
endpackage

// File: rtl/dpram_port_arbiter_if.sv
// Requester-side bus of the arbiter: flat-packed request fields and per-requester responses.
interface dpram_port_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 6,
    parameter int DW   = 64
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [NREQ*DW-1:0] rdata;

    modport master (
        output req, req_we, req_addr, req_wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dpram_port_arbiter_rr_pick2.sv
// Combinational round-robin picker: first and second active requester scanning from ptr.
module rr_pick2 #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] first_oh,
    output logic [NREQ-1:0] second_oh,
    output logic            first_vld,
    output logic            second_vld
);
    localparam int SW = PW + 1;

    logic [SW-1:0] sum_s;
    logic [PW-1:0] idx_s;
    logic          hit_s;

    // Walk the requesters in rotated order; each index is visited exactly once
    always_comb begin
        first_oh   = {NREQ{1'b0}};
        second_oh  = {NREQ{1'b0}};
        first_vld  = 1'b0;
        second_vld = 1'b0;
        sum_s      = {SW{1'b0}};
        idx_s      = {PW{1'b0}};
        hit_s      = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            sum_s            = {1'b0, ptr} + SW'(k);
            sum_s            = (sum_s >= SW'(NREQ)) ? sum_s - SW'(NREQ) : sum_s;
            idx_s            = sum_s[PW-1:0];
            hit_s            = req[idx_s];
            first_oh[idx_s]  = hit_s & ~first_vld;
            second_oh[idx_s] = hit_s & first_vld & ~second_vld;
            second_vld       = second_vld | (hit_s & first_vld);
            first_vld        = first_vld | hit_s;
        end
    end
endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares both ports of the 64x64 dual-port RAM among NREQ requesters, two grants per cycle,
// deferring the port B candidate when it would collide with port A on a write.
module dpram_port_arbiter
    import dpram_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = dpram_pkg::AW,
    parameter int DW   = dpram_pkg::DW
) (
    input  logic               clk,
    input  logic               rst_n,
    dpram_port_arbiter_if.slave bus,
    output logic [COLL_W-1:0]  coll_cnt,
    output logic [1:0]         ram_rw,
    output logic [AW-1:0]      ram_addr_a,
    output logic [AW-1:0]      ram_addr_b,
    output logic [DW-1:0]      ram_din_a,
    output logic [DW-1:0]      ram_din_b,
    input  logic [DW-1:0]      ram_dout_a,
    input  logic [DW-1:0]      ram_dout_b
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]     ptr_r, ptr_nxt_s, idx_a_s, idx_b_s, last_s;
    logic [NREQ-1:0]   first_oh_s, second_oh_s, gnt_s;
    logic              first_vld_s, second_vld_s;
    logic              we_a_s, we_b_s;
    logic [AW-1:0]     addr_a_s, addr_b_s;
    logic [DW-1:0]     wdata_a_s, wdata_b_s;
    logic              conflict_s, grant_a_s, grant_b_s;
    logic [NREQ-1:0]   rvalid_r;
    logic [NREQ*DW-1:0] rdata_r;
    logic [COLL_W-1:0] coll_cnt_r;

    rr_pick2 #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req        (bus.req),
        .ptr        (ptr_r),
        .first_oh   (first_oh_s),
        .second_oh  (second_oh_s),
        .first_vld  (first_vld_s),
        .second_vld (second_vld_s)
    );

    // One-hot to field mux for both candidates, conflict check and port drive
    always_comb begin
        we_a_s    = 1'b0;
        we_b_s    = 1'b0;
        addr_a_s  = {AW{1'b0}};
        addr_b_s  = {AW{1'b0}};
        wdata_a_s = {DW{1'b0}};
        wdata_b_s = {DW{1'b0}};
        idx_a_s   = {PW{1'b0}};
        idx_b_s   = {PW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            we_a_s    = we_a_s | (first_oh_s[i] & bus.req_we[i]);
            we_b_s    = we_b_s | (second_oh_s[i] & bus.req_we[i]);
            addr_a_s  = addr_a_s | ({AW{first_oh_s[i]}} & bus.req_addr[i*AW +: AW]);
            addr_b_s  = addr_b_s | ({AW{second_oh_s[i]}} & bus.req_addr[i*AW +: AW]);
            wdata_a_s = wdata_a_s | ({DW{first_oh_s[i]}} & bus.req_wdata[i*DW +: DW]);
            wdata_b_s = wdata_b_s | ({DW{second_oh_s[i]}} & bus.req_wdata[i*DW +: DW]);
            idx_a_s   = idx_a_s | (first_oh_s[i] ? PW'(i) : {PW{1'b0}});
            idx_b_s   = idx_b_s | (second_oh_s[i] ? PW'(i) : {PW{1'b0}});
        end

        conflict_s = first_vld_s & second_vld_s & (addr_a_s == addr_b_s) & (we_a_s | we_b_s);
        // Gating with rst_n keeps the RAM from seeing a write while reset is held
        grant_a_s  = rst_n & first_vld_s;
        grant_b_s  = rst_n & second_vld_s & ~conflict_s;

        gnt_s      = ({NREQ{grant_a_s}} & first_oh_s) | ({NREQ{grant_b_s}} & second_oh_s);
        ram_rw     = {grant_b_s & we_b_s, grant_a_s & we_a_s};
        ram_addr_a = grant_a_s ? addr_a_s : {AW{1'b0}};
        ram_addr_b = grant_b_s ? addr_b_s : {AW{1'b0}};
        ram_din_a  = grant_a_s ? wdata_a_s : {DW{1'b0}};
        ram_din_b  = grant_b_s ? wdata_b_s : {DW{1'b0}};

        last_s = grant_b_s ? idx_b_s : idx_a_s;
        if (!grant_a_s) begin
            ptr_nxt_s = ptr_r;
        end else if (last_s == PW'(NREQ - 1)) begin
            ptr_nxt_s = {PW{1'b0}};
        end else begin
            ptr_nxt_s = last_s + PW'(1);
        end
    end

    // Priority pointer, collision counter and read-return capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r      <= {PW{1'b0}};
            rvalid_r   <= {NREQ{1'b0}};
            rdata_r    <= {(NREQ*DW){1'b0}};
            coll_cnt_r <= {COLL_W{1'b0}};
        end else begin
            ptr_r <= ptr_nxt_s;
            if (conflict_s) begin
                coll_cnt_r <= sat_inc(coll_cnt_r);
            end
            for (int i = 0; i < NREQ; i++) begin
                rvalid_r[i] <= gnt_s[i] & ~bus.req_we[i];
                if (gnt_s[i] & ~bus.req_we[i]) begin
                    rdata_r[i*DW +: DW] <= first_oh_s[i] ? ram_dout_a : ram_dout_b;
                end
            end
        end
    end

    assign bus.gnt    = gnt_s;
    assign bus.rvalid = rvalid_r;
    assign bus.rdata  = rdata_r;
    assign coll_cnt   = coll_cnt_r;
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Randomized + directed bench: a cycle-level reference model checks grants and RAM drive,
// and a monitor checks read returns against a scoreboard queue per requester.
module tb_dpram_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 6;
    localparam int DW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [15:0]   coll_cnt;
    logic [1:0]    ram_rw;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [DW-1:0] ram_din_a, ram_din_b, ram_dout_a, ram_dout_b;

    dpram_port_arbiter_if #(.NREQ(N), .AW(AW), .DW(DW)) bus ();

    dpram_port_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .coll_cnt   (coll_cnt),
        .ram_rw     (ram_rw),
        .ram_addr_a (ram_addr_a),
        .ram_addr_b (ram_addr_b),
        .ram_din_a  (ram_din_a),
        .ram_din_b  (ram_din_b),
        .ram_dout_a (ram_dout_a),
        .ram_dout_b (ram_dout_b)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        if (i == 5) return 64'h0000_0000_0000_DEAD;
        return 64'hA5A5_0000_0000_0000 + 64'(i) * 64'h0000_0000_0001_0101;
    endfunction

    // Behavioural dual-port RAM: combinational read, write on rising edge
    logic [DW-1:0] mem [64];
    logic          mem_init;
    assign ram_dout_a = mem[ram_addr_a];
    assign ram_dout_b = mem[ram_addr_b];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else begin
            if (ram_rw[0]) mem[ram_addr_a] <= ram_din_a;
            if (ram_rw[1]) mem[ram_addr_b] <= ram_din_b;
        end
    end

    int tests = 0;
    int fails = 0;

    bit            p_req  [N];
    bit            p_we   [N];
    logic [AW-1:0] p_addr [N];
    logic [DW-1:0] p_data [N];
    logic [DW-1:0] ref_mem [64];
    logic [DW-1:0] exp_q [N][$];
    int            wait_cnt [N];
    int            m_ptr, m_coll, gen_mode;
    bit            rst_req;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every rvalid pops the scoreboard entry queued at grant time
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (bus.rvalid[i]) begin
                if (exp_q[i].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rvalid_unexpected req%0d: got rvalid=1, expected 0 (t=%0t)", i, $time);
                end else begin
                    chk($sformatf("rdata_req%0d", i), bus.rdata[i*DW +: DW], exp_q[i].pop_front());
                end
            end
        end
    end

    task automatic gen_new();
        for (int i = 0; i < N; i++) begin
            if (!p_req[i]) begin
                if (gen_mode == 2) begin
                    p_req[i]  = 1'b1;
                    p_we[i]   = 1'b0;
                    p_addr[i] = AW'(40 + i);
                    p_data[i] = {$urandom, $urandom};
                end else if ($urandom_range(0, 3) != 0) begin
                    p_req[i]  = 1'b1;
                    p_we[i]   = 1'($urandom_range(0, 1));
                    p_addr[i] = AW'($urandom_range(0, 5));
                    p_data[i] = {$urandom, $urandom};
                end
            end
        end
    endtask

    task automatic model_check();
        int hits[$];
        int a, b, last;
        bit conf;
        logic [N-1:0]  e_gnt;
        logic [1:0]    e_rw;
        logic [AW-1:0] ea, eb;
        logic [DW-1:0] da, db;
        for (int i = 0; i < N; i++) begin
            if (exp_q[i].size() != 0) begin
                tests++;
                fails++;
                $display("FAIL rvalid_missing req%0d: got no rvalid, expected %0d return(s)", i, exp_q[i].size());
                exp_q[i].delete();
            end
        end
        if (!rst_n) begin
            chk("gnt_in_reset", 64'(bus.gnt), 64'd0);
            chk("ram_rw_in_reset", 64'(ram_rw), 64'd0);
            chk("rvalid_in_reset", 64'(bus.rvalid), 64'd0);
            chk("coll_in_reset", 64'(coll_cnt), 64'd0);
            for (int i = 0; i < N; i++) chk("rdata_in_reset", bus.rdata[i*DW +: DW], 64'd0);
            m_ptr  = 0;
            m_coll = 0;
            for (int i = 0; i < N; i++) wait_cnt[i] = 0;
            return;
        end
        for (int k = 0; k < N; k++) begin
            int i = (m_ptr + k) % N;
            if (p_req[i]) hits.push_back(i);
        end
        a = (hits.size() > 0) ? hits[0] : -1;
        b = (hits.size() > 1) ? hits[1] : -1;
        conf = 1'b0;
        if (b >= 0 && p_addr[a] == p_addr[b] && (p_we[a] || p_we[b])) begin
            b    = -1;
            conf = 1'b1;
        end
        e_gnt = '0; e_rw = '0; ea = '0; eb = '0; da = '0; db = '0;
        if (a >= 0) begin
            e_gnt[a] = 1'b1; e_rw[0] = p_we[a]; ea = p_addr[a]; da = p_data[a];
        end
        if (b >= 0) begin
            e_gnt[b] = 1'b1; e_rw[1] = p_we[b]; eb = p_addr[b]; db = p_data[b];
        end
        chk("gnt", 64'(bus.gnt), 64'(e_gnt));
        chk("ram_rw", 64'(ram_rw), 64'(e_rw));
        chk("ram_addr_a", 64'(ram_addr_a), 64'(ea));
        chk("ram_addr_b", 64'(ram_addr_b), 64'(eb));
        chk("ram_din_a", ram_din_a, da);
        chk("ram_din_b", ram_din_b, db);
        chk("coll_cnt", 64'(coll_cnt), 64'(m_coll));

        for (int i = 0; i < N; i++) begin
            if (e_gnt[i] && !p_we[i]) exp_q[i].push_back(ref_mem[p_addr[i]]);
        end
        for (int i = 0; i < N; i++) begin
            if (e_gnt[i]) begin
                if (p_we[i]) ref_mem[p_addr[i]] = p_data[i];
                if (gen_mode == 2) begin
                    tests++;
                    if (wait_cnt[i] > 1) begin
                        fails++;
                        $display("FAIL fair_wait req%0d: got %0d cycles, expected <= 1", i, wait_cnt[i]);
                    end
                end
                p_req[i]    = 1'b0;
                wait_cnt[i] = 0;
            end else if (p_req[i]) begin
                wait_cnt[i]++;
            end
        end
        if (conf && m_coll < 65535) m_coll++;
        if (a >= 0) begin
            last  = (b >= 0) ? b : a;
            m_ptr = (last + 1) % N;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        rst_n = rst_req;
        if (gen_mode != 0) gen_new();
        for (int i = 0; i < N; i++) begin
            bus.req[i]                = p_req[i];
            bus.req_we[i]             = p_we[i];
            bus.req_addr[i*AW +: AW]  = p_addr[i];
            bus.req_wdata[i*DW +: DW] = p_data[i];
        end
        @(negedge clk);
        model_check();
    endtask

    task automatic set_req(input int i, input bit we, input int addr, input logic [DW-1:0] d);
        p_req[i]  = 1'b1;
        p_we[i]   = we;
        p_addr[i] = AW'(addr);
        p_data[i] = d;
    endtask

    task automatic drain();
        for (int n = 0; n < 12; n++) begin
            bit busy = 1'b0;
            for (int i = 0; i < N; i++) busy |= p_req[i];
            if (busy) step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rst_req = 1'b0; mem_init = 1'b1; gen_mode = 0;
        m_ptr = 0; m_coll = 0;
        bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        for (int i = 0; i < N; i++) begin
            p_req[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = '0; p_data[i] = '0; wait_cnt[i] = 0;
        end

        // Reset with a request already held: nothing may be granted
        set_req(0, 1'b0, 5, 64'h0);
        repeat (3) step();
        mem_init = 1'b0;
        rst_req  = 1'b1;
        step();                                   // single read of addr 5
        set_req(3, 1'b0, 30, 64'h0);
        step();                                   // moves pointer back to 0
        set_req(0, 1'b1, 3, 64'h11);
        set_req(2, 1'b0, 9, 64'h0);
        step();                                   // dual grant
        set_req(0, 1'b0, 1, 64'h0);
        step();                                   // pointer to 1
        set_req(1, 1'b1, 7, 64'h1111_0000_0000_0001);
        set_req(3, 1'b1, 7, 64'h3333_0000_0000_0003);
        step();                                   // write conflict
        step();
        step();
        chk("ram7_final", mem[7], 64'h3333_0000_0000_0003);
        set_req(0, 1'b0, 12, 64'h0);
        set_req(1, 1'b0, 12, 64'h0);
        step();                                   // same-address reads
        step();

        gen_mode = 2;
        repeat (12) step();
        gen_mode = 0;
        drain();

        gen_mode = 1;
        repeat (400) step();
        gen_mode = 0;
        drain();
        step();

        // Reset in the cycle after a read grant, requests held across it
        set_req(0, 1'b0, 5, 64'h0);
        step();
        set_req(0, 1'b0, 2, 64'h0);
        set_req(3, 1'b0, 4, 64'h0);
        rst_req = 1'b0;
        step();
        step();
        rst_req = 1'b1;
        step();
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
